// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter, its caches and the RAM.
`timescale 1ns/1ps
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W    = 10;
  localparam int unsigned MEM_DATA_W    = 20;
  localparam int unsigned MEM_BURST_LEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } arb_state_e;

  // One-hot grant vector for a one-bit owner index.
  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not served last.
`timescale 1ns/1ps
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // Pure combinational decision used while the arbiter is idle.
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between two cache controllers, granting
// bursts of up to BURST_LEN beats with round-robin fairness.
//
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate between pending requests
//   ST_ISSUE | owner's address/data/we presented to the RAM
//   ST_RESP  | RAM data back; owner's ready pulses
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned BURST_LEN = MEM_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_mem_req,
  input  logic              c0_mem_rw,
  input  logic [ADDR_W-1:0] c0_mem_addr,
  input  logic [DATA_W-1:0] c0_mem_data_to_ram,
  output logic              c0_mem_ready,
  output logic [DATA_W-1:0] c0_mem_data_from_ram,
  input  logic              c1_mem_req,
  input  logic              c1_mem_rw,
  input  logic [ADDR_W-1:0] c1_mem_addr,
  input  logic [DATA_W-1:0] c1_mem_data_to_ram,
  output logic              c1_mem_ready,
  output logic [DATA_W-1:0] c1_mem_data_from_ram,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  arb_state_e        state_q;
  logic              owner_q;
  logic              last_q;
  logic [BEAT_W-1:0] beat_q;

  logic              pick_valid;
  logic              pick_winner;

  logic              owner_req;
  logic              owner_rw;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;

  rr_pick2 u_pick (
    .req    ({c1_mem_req, c0_mem_req}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Select the current owner's request fields; they are used unregistered.
  always_comb begin
    owner_req   = owner_q ? c1_mem_req         : c0_mem_req;
    owner_rw    = owner_q ? c1_mem_rw          : c0_mem_rw;
    owner_addr  = owner_q ? c1_mem_addr        : c0_mem_addr;
    owner_wdata = owner_q ? c1_mem_data_to_ram : c0_mem_data_to_ram;
  end

  // Arbitration FSM: state, owner, last-served and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_winner;
            beat_q  <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (owner_req) begin
            state_q <= ST_RESP;
          end else begin
            // Abandoned beat still counts as this owner's turn.
            last_q  <= owner_q;
            state_q <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (beat_q == BEAT_LAST) begin
            last_q  <= owner_q;
            state_q <= ST_IDLE;
          end else begin
            beat_q  <= beat_q + BEAT_W'(1);
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode from the current state; everything idles at zero.
  always_comb begin
    grant                = 2'b00;
    busy                 = 1'b0;
    ram_we               = 1'b0;
    ram_addr             = '0;
    ram_wdata            = '0;
    c0_mem_ready         = 1'b0;
    c1_mem_ready         = 1'b0;
    c0_mem_data_from_ram = '0;
    c1_mem_data_from_ram = '0;
    case (state_q)
      ST_ISSUE: begin
        grant = onehot2(owner_q);
        busy  = 1'b1;
        if (owner_req) begin
          ram_we    = owner_rw;
          ram_addr  = owner_addr;
          ram_wdata = owner_wdata;
        end
      end
      ST_RESP: begin
        grant = onehot2(owner_q);
        busy  = 1'b1;
        if (owner_q) begin
          c1_mem_ready         = 1'b1;
          c1_mem_data_from_ram = ram_rdata;
        end else begin
          c0_mem_ready         = 1'b1;
          c0_mem_data_from_ram = ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
